kamikaze_fetch: RTL and testbench

Instruction-fetch front end of the kamikaze core: the initiator side of the instruction-memory port. It drives word addresses into the synchronous instruction memory, captures the returned words one cycle later, and buffers them in a small FIFO. Decode drains that FIFO through a valid/ready handshake. Branch/jump redirects flush all buffered and in-flight words and restart fetch at the new PC.

---
 rtl/kamikaze_fetch.sv | 99 +++++++++
 tb/tb_kamikaze_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/kamikaze_fetch.sv
// Purpose : instruction-fetch front end; issues word addresses to a 1-cycle sync memory, buffers {pc, word}.
// Latency : first instruction valid 2 cycles after reset release / 3 cycles after a redirect.
// Backpr. : credit-based; fetch stops once buffered + in-flight words reach BUF_DEPTH, nothing is dropped.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   im_addr_o / im_data_i        memory request address / read data returned one cycle later
//   redirect_i / redirect_pc_i   flush buffered and in-flight words, restart fetch at redirect_pc_i
//   inst_valid_o/inst_o/inst_pc_o/inst_ready_i   valid/ready instruction stream towards decode
module kamikaze_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_fetch_pc;
    logic          r_pend;
    logic [31:0]   r_pend_pc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_buf_pc  [BUF_DEPTH];
    logic [31:0]   r_buf_dat [BUF_DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [CW:0]   w_occ;

    assign im_addr_o    = {r_fetch_pc[31:2], 2'b00};
    assign inst_valid_o = (r_count != '0);
    assign inst_o       = inst_valid_o ? r_buf_dat[r_rd_ptr] : 32'h0;
    assign inst_pc_o    = inst_valid_o ? r_buf_pc[r_rd_ptr]  : 32'h0;

    assign w_pop  = inst_valid_o && inst_ready_i;
    assign w_push = r_pend && !redirect_i;

    // Occupancy after this cycle's pop, counting the in-flight word as already buffered.
    // A pop can only happen with r_count >= 1, so the subtraction never underflows.
    assign w_occ   = {1'b0, r_count} + (CW+1)'(r_pend) - (CW+1)'(w_pop);
    assign w_issue = !redirect_i && (w_occ < (CW+1)'(BUF_DEPTH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_pend     <= 1'b0;
            r_pend_pc  <= 32'h0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_i) begin
            // Everything buffered or in flight belongs to the old path.
            r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            r_pend     <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_pend_pc  <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while r_count says they are live.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            r_buf_pc[r_wr_ptr]  <= r_pend_pc;
            r_buf_dat[r_wr_ptr] <= im_data_i;
        end
    end

endmodule

// File: tb/tb_kamikaze_fetch.sv
module tb_kamikaze_fetch;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] im_addr_o;
    logic [31:0] im_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb_q[$];

    kamikaze_fetch #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .im_addr_o    (im_addr_o),
        .im_data_i    (im_data_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_ready_i (inst_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Synchronous instruction memory: memory[word i] = i.
    always @(posedge clk_i) im_data_i <= {2'b00, im_addr_o[31:2]};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected transfers: n consecutive words starting at byte address pc0.
    task automatic exp_seq(input logic [31:0] pc0, input int n);
        logic [31:0] pc;
        for (int k = 0; k < n; k++) begin
            pc = pc0 + 32'(4 * k);
            sb_q.push_back({pc, 2'b00, pc[31:2]});
        end
    endtask

    // Monitor: every handshake must match the next expected {pc, inst}.
    always @(negedge clk_i) begin
        if (inst_valid_o && inst_ready_i) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_xfer", {inst_pc_o, inst_o}, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                chk("xfer", {inst_pc_o, inst_o}, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"},  {32'h0, im_addr_o},         {32'h0, 32'h0000_0100});
        chk({tag, "_valid"}, {63'h0, inst_valid_o},      64'h0);
        chk({tag, "_data"},  {inst_pc_o, inst_o},        64'h0);
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle with rst_i low).
    task automatic do_reset();
        tick();
        rst_i        = 1'b1;
        redirect_i   = 1'b0;
        inst_ready_i = 1'b0;
        tick();
        @(negedge clk_i);
        chk_reset_outputs("reset");
        tick();
        rst_i = 1'b0;
    endtask

    task automatic end_phase(input string tag);
        inst_ready_i = 1'b0;
        redirect_i   = 1'b0;
        @(negedge clk_i);
        chk({tag, "_drained"}, 64'(sb_q.size()), 64'h0);
        sb_q.delete();
    endtask

    initial begin
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        inst_ready_i  = 1'b0;

        // Startup + backpressure: ready low in cycles 5..12.
        do_reset();
        exp_seq(32'h100, 11);
        for (int c = 0; c <= 20; c++) begin
            inst_ready_i = !(c >= 5 && c <= 12);
            @(negedge clk_i);
            if (c == 0) chk("c0_addr", {32'h0, im_addr_o}, 64'h100);
            if (c <= 1) chk("early_valid", {63'h0, inst_valid_o}, 64'h0);
            if (c == 2) chk("c2_head", {31'h0, inst_valid_o, inst_pc_o}, {31'h0, 1'b1, 32'h100});
            if (c >= 6 && c <= 12) begin
                chk("bp_addr_frozen", {32'h0, im_addr_o}, 64'h114);
                chk("bp_head_stable", {inst_pc_o, inst_o}, {32'h10C, 32'h43});
            end
            tick();
        end
        end_phase("bp");

        // Plain redirect in cycle 10 to 0x2002.
        do_reset();
        exp_seq(32'h100, 9);
        exp_seq(32'h2000, 4);
        for (int c = 0; c <= 16; c++) begin
            inst_ready_i  = 1'b1;
            redirect_i    = (c == 10);
            redirect_pc_i = 32'h0000_2002;
            @(negedge clk_i);
            if (c == 11) chk("rd_addr", {32'h0, im_addr_o}, 64'h2000);
            if (c == 11 || c == 12) chk("rd_gap", {63'h0, inst_valid_o}, 64'h0);
            if (c == 13) chk("rd_head", {inst_pc_o, inst_o}, {32'h2000, 32'h800});
            tick();
        end
        end_phase("redir");

        // Redirect with a full FIFO and a simultaneous pop in cycle 8.
        do_reset();
        exp_seq(32'h100, 4);
        exp_seq(32'h3000, 4);
        for (int c = 0; c <= 14; c++) begin
            inst_ready_i  = !(c >= 5 && c <= 7);
            redirect_i    = (c == 8);
            redirect_pc_i = 32'h0000_3000;
            @(negedge clk_i);
            if (c == 8) chk("full_addr", {31'h0, inst_valid_o, im_addr_o}, {31'h0, 1'b1, 32'h114});
            if (c == 9 || c == 10) chk("full_empty", {63'h0, inst_valid_o}, 64'h0);
            if (c == 11) chk("full_head", {inst_pc_o, inst_o}, {32'h3000, 32'hC00});
            tick();
        end
        end_phase("rdfull");

        // Address wrap: redirect in cycle 3 to 0xFFFF_FFF8.
        do_reset();
        exp_seq(32'h100, 2);
        exp_seq(32'hFFFF_FFF8, 4);
        for (int c = 0; c <= 9; c++) begin
            inst_ready_i  = 1'b1;
            redirect_i    = (c == 3);
            redirect_pc_i = 32'hFFFF_FFF8;
            @(negedge clk_i);
            if (c == 6) chk("wrap_addr", {32'h0, im_addr_o}, 64'h0);
            tick();
        end
        end_phase("wrap");

        // Reset for one cycle while stalled with full credit (count + pend = depth).
        do_reset();
        exp_seq(32'h100, 3);
        exp_seq(32'h100, 4);
        for (int c = 0; c <= 11; c++) begin
            inst_ready_i = (c != 5);
            rst_i        = (c == 5);
            @(negedge clk_i);
            if (c == 6) chk_reset_outputs("midrst");
            if (c == 7) chk("midrst_c1", {63'h0, inst_valid_o}, 64'h0);
            if (c == 8) chk("midrst_c2", {31'h0, inst_valid_o, inst_pc_o}, {31'h0, 1'b1, 32'h100});
            tick();
        end
        end_phase("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
